// File: rtl/bus_sequencer_pkg.sv
// bus_sequencer shared types: states, opcode classes, bus codes
// and the control bundle produced by the output decoder.
package bus_sequencer_pkg;

  localparam int CODE_W = 5;

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7,
    PAUSE, HALT, FAULT
  } state_t;

  localparam logic [4:0] SRC_NONE = 5'd0;
  localparam logic [4:0] SRC_REG  = 5'd1;
  localparam logic [4:0] SRC_PC   = 5'd2;
  localparam logic [4:0] SRC_MDR  = 5'd3;
  localparam logic [4:0] SRC_ZHI  = 5'd4;
  localparam logic [4:0] SRC_ZLO  = 5'd5;
  localparam logic [4:0] SRC_COUT = 5'd8;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_LD   = 5'd17;
  localparam logic [4:0] OP_ST   = 5'd18;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [4:0] ALU_ADD = 5'd0;

  typedef enum logic [2:0] {
    CL_R, CL_IMM, CL_MD, CL_LD,
    CL_ST, CL_NOP, CL_HALT, CL_ILL
  } op_class_t;

  typedef struct packed {
    logic [4:0] src;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       pc_in;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       y_in;
    logic       z_in;
    logic       hi_in;
    logic       lo_in;
    logic       mdr_from_mem;
    logic       inc_pc;
    logic       mem_read;
    logic       mem_write;
    logic       running;
    logic [4:0] alu_op;
  } ctrl_t;

  function automatic op_class_t classify(
    input logic [CODE_W-1:0] op
  );
    case (op) inside
      [OP_ADD:OP_ROL]:  return CL_R;
      [OP_ADDI:OP_ORI]: return CL_IMM;
      OP_MUL, OP_DIV:   return CL_MD;
      OP_LD:            return CL_LD;
      OP_ST:            return CL_ST;
      OP_NOP:           return CL_NOP;
      OP_HALT:          return CL_HALT;
      default:          return CL_ILL;
    endcase
  endfunction

endpackage

// File: rtl/seq_output_decode.sv
// Control-step decoder: maps the current step and opcode class
// to the bus driver select and every latch/memory enable.
module seq_output_decode
  import bus_sequencer_pkg::*;
(
  input  state_t            state,
  input  logic [CODE_W-1:0] ir_op,
  output ctrl_t             ctrl
);

  op_class_t cl;

  assign cl = classify(ir_op);

  always_comb begin
    ctrl = '0;
    ctrl.src = SRC_NONE;
    ctrl.running = 1'b1;
    ctrl.alu_op = (state == T0 || cl == CL_LD || cl == CL_ST)
                ? ALU_ADD : ir_op;
    unique case (state)
      T0: begin
        ctrl.src = SRC_PC;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in = 1'b1;
      end
      T1: begin
        ctrl.src = SRC_ZLO;
        ctrl.pc_in = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.mdr_in = 1'b1;
        ctrl.mdr_from_mem = 1'b1;
      end
      T2: begin
        ctrl.src = SRC_MDR;
        ctrl.ir_in = 1'b1;
      end
      T3: begin
        unique case (cl)
          CL_R, CL_IMM, CL_LD, CL_ST: begin
            ctrl.grb = 1'b1;
            ctrl.src = SRC_REG;
            ctrl.y_in = 1'b1;
          end
          CL_MD: begin
            ctrl.gra = 1'b1;
            ctrl.src = SRC_REG;
            ctrl.y_in = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        unique case (cl)
          CL_R: begin
            ctrl.grc = 1'b1;
            ctrl.src = SRC_REG;
            ctrl.z_in = 1'b1;
          end
          CL_IMM, CL_LD, CL_ST: begin
            ctrl.src = SRC_COUT;
            ctrl.z_in = 1'b1;
          end
          CL_MD: begin
            ctrl.grb = 1'b1;
            ctrl.src = SRC_REG;
            ctrl.z_in = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        unique case (cl)
          CL_R, CL_IMM: begin
            ctrl.src = SRC_ZLO;
            ctrl.gra = 1'b1;
            ctrl.r_in = 1'b1;
          end
          CL_MD: begin
            ctrl.src = SRC_ZLO;
            ctrl.lo_in = 1'b1;
          end
          CL_LD, CL_ST: begin
            ctrl.src = SRC_ZLO;
            ctrl.mar_in = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        unique case (cl)
          CL_MD: begin
            ctrl.src = SRC_ZHI;
            ctrl.hi_in = 1'b1;
          end
          CL_LD: begin
            ctrl.mem_read = 1'b1;
            ctrl.mdr_in = 1'b1;
            ctrl.mdr_from_mem = 1'b1;
          end
          CL_ST: begin
            ctrl.gra = 1'b1;
            ctrl.src = SRC_REG;
            ctrl.mdr_in = 1'b1;
          end
          default: ;
        endcase
      end
      T7: begin
        unique case (cl)
          CL_LD: begin
            ctrl.src = SRC_MDR;
            ctrl.gra = 1'b1;
            ctrl.r_in = 1'b1;
          end
          CL_ST: ctrl.mem_write = 1'b1;
          default: ;
        endcase
      end
      default: ctrl.running = 1'b0;
    endcase
  end

endmodule

// File: rtl/bus_sequencer.sv
// Control-step sequencer for the shared datapath bus: state
// register, memory-wait timeout counter and sticky fault flag.
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int SRC_W       = 5,
  parameter int OP_W        = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [OP_W-1:0]  ir_op,
  input  logic             mem_ready,
  input  logic             stop,
  output logic [SRC_W-1:0] src_sel,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic             r_in,
  output logic             pc_in,
  output logic             ir_in,
  output logic             mar_in,
  output logic             mdr_in,
  output logic             y_in,
  output logic             z_in,
  output logic             hi_in,
  output logic             lo_in,
  output logic             mdr_from_mem,
  output logic             inc_pc,
  output logic [OP_W-1:0]  alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             running,
  output logic             fault
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  state_t            state;
  state_t            boundary;
  logic [CW-1:0]     cnt;
  logic              fault_q;
  logic              wait_st;
  logic [CODE_W-1:0] op;
  op_class_t         cl;
  ctrl_t             c;

  assign op = CODE_W'(ir_op);
  assign cl = classify(op);
  assign wait_st = (state == T1)
                || (state == T6 && cl == CL_LD)
                || (state == T7 && cl == CL_ST);
  assign boundary = stop ? PAUSE : T0;

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= T0;
      cnt <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt <= '0;
      if (wait_st && !mem_ready) begin
        if (cnt == LAST) begin
          state <= FAULT;
          fault_q <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        unique case (state)
          T0: state <= T1;
          T1: state <= T2;
          T2: state <= T3;
          T3: begin
            unique case (cl)
              CL_ILL: begin
                state <= FAULT;
                fault_q <= 1'b1;
              end
              CL_NOP:  state <= boundary;
              CL_HALT: state <= HALT;
              default: state <= T4;
            endcase
          end
          T4: state <= T5;
          T5: begin
            if (cl == CL_MD || cl == CL_LD || cl == CL_ST)
              state <= T6;
            else
              state <= boundary;
          end
          T6: begin
            if (cl == CL_LD || cl == CL_ST)
              state <= T7;
            else
              state <= boundary;
          end
          T7: state <= boundary;
          PAUSE: if (!stop) state <= T0;
          default: state <= state;
        endcase
      end
    end
  end

  seq_output_decode u_dec (
    .state (state),
    .ir_op (op),
    .ctrl  (c)
  );

  assign src_sel      = SRC_W'(c.src);
  assign gra          = c.gra;
  assign grb          = c.grb;
  assign grc          = c.grc;
  assign r_in         = c.r_in;
  assign pc_in        = c.pc_in;
  assign ir_in        = c.ir_in;
  assign mar_in       = c.mar_in;
  assign mdr_in       = c.mdr_in;
  assign y_in         = c.y_in;
  assign z_in         = c.z_in;
  assign hi_in        = c.hi_in;
  assign lo_in        = c.lo_in;
  assign mdr_from_mem = c.mdr_from_mem;
  assign inc_pc       = c.inc_pc;
  assign alu_op       = OP_W'(c.alu_op);
  assign mem_read     = c.mem_read;
  assign mem_write    = c.mem_write;
  assign running      = c.running;
  assign fault        = fault_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: per-instruction step
// sequences, memory waits, timeout, pause, halt and clear.
module tb_bus_sequencer;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic [4:0] ir_op = 5'd0;
  logic       mem_ready = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] src_sel;
  logic       gra, grb, grc, r_in, pc_in, ir_in;
  logic       mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
  logic       mdr_from_mem, inc_pc;
  logic [4:0] alu_op;
  logic       mem_read, mem_write, running, fault;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bus_sequencer #(.MEM_TIMEOUT(8)) dut (
    .clock        (clock),
    .clear        (clear),
    .ir_op        (ir_op),
    .mem_ready    (mem_ready),
    .stop         (stop),
    .src_sel      (src_sel),
    .gra          (gra),
    .grb          (grb),
    .grc          (grc),
    .r_in         (r_in),
    .pc_in        (pc_in),
    .ir_in        (ir_in),
    .mar_in       (mar_in),
    .mdr_in       (mdr_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .hi_in        (hi_in),
    .lo_in        (lo_in),
    .mdr_from_mem (mdr_from_mem),
    .inc_pc       (inc_pc),
    .alu_op       (alu_op),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .running      (running),
    .fault        (fault)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    stop = 1'b0;
    mem_ready = 1'b0;
    ir_op = 5'd0;
    do_clear();
    step();
    do_clear();
    checks++;
    if (src_sel !== 5'd2) begin
      failures++;
      $display("FAIL reset_src got=%0d exp=2", src_sel);
    end
    checks++;
    if ({mar_in, inc_pc, z_in, pc_in, mem_read, mem_write}
        !== 6'b111000) begin
      failures++;
      $display("FAIL reset_en got=%b exp=111000",
        {mar_in, inc_pc, z_in, pc_in, mem_read, mem_write});
    end
    checks++;
    if ({running, fault, alu_op} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_flags run=%b fault=%b alu=%0d exp 1 0 0",
        running, fault, alu_op);
    end
  endtask

  task automatic test_add();
    logic [4:0] exp_src [6];
    exp_src = '{5'd2, 5'd5, 5'd3, 5'd1, 5'd1, 5'd5};
    ir_op = 5'd0;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (src_sel !== exp_src[i] || r_in !== 1'(i == 5)) begin
        failures++;
        $display("FAIL add_seq cyc=%0d src=%0d r_in=%b exp %0d %b",
          i, src_sel, r_in, exp_src[i], 1'(i == 5));
      end
      if (i == 1) begin
        checks++;
        if ({mem_read, pc_in, mdr_from_mem} !== 3'b111) begin
          failures++;
          $display("FAIL add_t1 got=%b exp=111",
            {mem_read, pc_in, mdr_from_mem});
        end
      end
      if (i == 4) begin
        checks++;
        if ({grb, grc, z_in, alu_op} !== {3'b011, 5'd0}) begin
          failures++;
          $display("FAIL add_t4 got=%b/%0d exp=011/0",
            {grb, grc, z_in}, alu_op);
        end
      end
      step();
    end
    checks++;
    if (src_sel !== 5'd2 || inc_pc !== 1'b1) begin
      failures++;
      $display("FAIL add_end src=%0d inc=%b exp 2 1",
        src_sel, inc_pc);
    end
  endtask

  task automatic test_mul();
    logic [4:0] exp_src [7];
    exp_src = '{5'd2, 5'd5, 5'd3, 5'd1, 5'd1, 5'd5, 5'd4};
    ir_op = 5'd15;
    mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (src_sel !== exp_src[i]
          || {lo_in, hi_in} !== {1'(i == 5), 1'(i == 6)}) begin
        failures++;
        $display("FAIL mul_seq cyc=%0d src=%0d lo=%b hi=%b exp %0d",
          i, src_sel, lo_in, hi_in, exp_src[i]);
      end
      if (i == 3) begin
        checks++;
        if ({gra, grb, y_in, alu_op} !== {3'b101, 5'd15}) begin
          failures++;
          $display("FAIL mul_t3 got=%b/%0d exp=101/15",
            {gra, grb, y_in}, alu_op);
        end
      end
      step();
    end
    checks++;
    if (src_sel !== 5'd2) begin
      failures++;
      $display("FAIL mul_end src=%0d exp=2", src_sel);
    end
  endtask

  task automatic test_ld();
    ir_op = 5'd17;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        checks++;
        if (src_sel !== 5'd8 || alu_op !== 5'd0 || z_in !== 1'b1) begin
          failures++;
          $display("FAIL ld_t4 src=%0d alu=%0d z=%b exp 8 0 1",
            src_sel, alu_op, z_in);
        end
      end
      step();
    end
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) mem_ready = 1'b1;
      checks++;
      if ({mem_read, mdr_in, mdr_from_mem} !== 3'b111
          || src_sel !== 5'd0) begin
        failures++;
        $display("FAIL ld_wait k=%0d rd/mdr/mem=%b src=%0d exp 111 0",
          k, {mem_read, mdr_in, mdr_from_mem}, src_sel);
      end
      step();
    end
    checks++;
    if (src_sel !== 5'd3 || {r_in, gra, mem_read} !== 3'b110) begin
      failures++;
      $display("FAIL ld_t7 src=%0d r/gra/rd=%b exp 3 110",
        src_sel, {r_in, gra, mem_read});
    end
    step();
    checks++;
    if (src_sel !== 5'd2) begin
      failures++;
      $display("FAIL ld_end src=%0d exp=2", src_sel);
    end
  endtask

  task automatic test_st();
    ir_op = 5'd18;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (src_sel !== 5'd1
        || {gra, mdr_in, mdr_from_mem, mem_write} !== 4'b1100) begin
      failures++;
      $display("FAIL st_t6 src=%0d gra/mdr/mem/wr=%b exp 1 1100",
        src_sel, {gra, mdr_in, mdr_from_mem, mem_write});
    end
    step();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) mem_ready = 1'b1;
      checks++;
      if (mem_write !== 1'b1 || src_sel !== 5'd0) begin
        failures++;
        $display("FAIL st_t7 k=%0d wr=%b src=%0d exp 1 0",
          k, mem_write, src_sel);
      end
      step();
    end
    checks++;
    if (src_sel !== 5'd2 || mem_write !== 1'b0) begin
      failures++;
      $display("FAIL st_end src=%0d wr=%b exp 2 0",
        src_sel, mem_write);
    end
  endtask

  task automatic test_nop();
    ir_op = 5'd26;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (src_sel !== 5'd0 || running !== 1'b1) begin
      failures++;
      $display("FAIL nop_t3 src=%0d run=%b exp 0 1", src_sel, running);
    end
    step();
    checks++;
    if (src_sel !== 5'd2) begin
      failures++;
      $display("FAIL nop_end src=%0d exp=2", src_sel);
    end
  endtask

  task automatic test_pause();
    ir_op = 5'd12;
    mem_ready = 1'b1;
    stop = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (src_sel !== 5'd8 || grc !== 1'b0) begin
      failures++;
      $display("FAIL addi_t4 src=%0d grc=%b exp 8 0", src_sel, grc);
    end
    stop = 1'b1;
    step();
    checks++;
    if (src_sel !== 5'd5 || {r_in, gra, running} !== 3'b111) begin
      failures++;
      $display("FAIL addi_t5 src=%0d r/gra/run=%b exp 5 111",
        src_sel, {r_in, gra, running});
    end
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (running !== 1'b0 || src_sel !== 5'd0
          || {r_in, pc_in, mar_in, z_in, mem_read} !== 5'b0) begin
        failures++;
        $display("FAIL pause k=%0d run=%b src=%0d exp 0 0",
          k, running, src_sel);
      end
      step();
    end
    stop = 1'b0;
    step();
    checks++;
    if (src_sel !== 5'd2 || running !== 1'b1) begin
      failures++;
      $display("FAIL pause_exit src=%0d run=%b exp 2 1",
        src_sel, running);
    end
  endtask

  task automatic test_halt();
    logic bad;
    bad = 1'b0;
    ir_op = 5'd27;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    for (int k = 0; k < 100; k++) begin
      if (running !== 1'b0 || src_sel !== 5'd0 || fault !== 1'b0)
        bad = 1'b1;
      step();
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL halt_hold run=%b src=%0d fault=%b exp 0 0 0",
        running, src_sel, fault);
    end
    do_clear();
  endtask

  task automatic test_illegal();
    ir_op = 5'd31;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if ({fault, running} !== 2'b10 || src_sel !== 5'd0) begin
      failures++;
      $display("FAIL illegal fault=%b run=%b src=%0d exp 1 0 0",
        fault, running, src_sel);
    end
    do_clear();
    checks++;
    if (fault !== 1'b0 || src_sel !== 5'd2) begin
      failures++;
      $display("FAIL illegal_clr fault=%b src=%0d exp 0 2",
        fault, src_sel);
    end
  endtask

  task automatic test_clear_mid();
    ir_op = 5'd17;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    mem_ready = 1'b0;
    step();
    step();
    checks++;
    if (mem_read !== 1'b1) begin
      failures++;
      $display("FAIL ldwait_pre rd=%b exp=1", mem_read);
    end
    do_clear();
    checks++;
    if (mem_read !== 1'b0 || src_sel !== 5'd2 || fault !== 1'b0) begin
      failures++;
      $display("FAIL clear_mid rd=%b src=%0d fault=%b exp 0 2 0",
        mem_read, src_sel, fault);
    end
  endtask

  task automatic test_timeout();
    ir_op = 5'd0;
    mem_ready = 1'b0;
    step();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem_read !== 1'b1 || fault !== 1'b0) begin
        failures++;
        $display("FAIL to_wait k=%0d rd=%b fault=%b exp 1 0",
          k, mem_read, fault);
      end
      step();
    end
    checks++;
    if ({fault, running, mem_read} !== 3'b100 || src_sel !== 5'd0) begin
      failures++;
      $display("FAIL timeout f/run/rd=%b src=%0d exp 100 0",
        {fault, running, mem_read}, src_sel);
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (fault !== 1'b1 || src_sel !== 5'd0) begin
      failures++;
      $display("FAIL fault_hold fault=%b src=%0d exp 1 0",
        fault, src_sel);
    end
    do_clear();
    checks++;
    if (fault !== 1'b0 || src_sel !== 5'd2 || running !== 1'b1) begin
      failures++;
      $display("FAIL fault_clr fault=%b src=%0d run=%b exp 0 2 1",
        fault, src_sel, running);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_ld();
    test_st();
    test_nop();
    test_pause();
    test_halt();
    test_illegal();
    test_clear_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
